// File: rtl/plot_queue.sv
// First-word fall-through pixel FIFO between the draw mux and the VGA adapter.
// Off-screen requests are clipped and overflowing requests are dropped; both are counted.
module plot_queue #(
    parameter int         DEPTH = 8,
    parameter logic [9:0] X_MAX = 10'd319,
    parameter logic [9:0] Y_MAX = 10'd239
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       writeEn,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic [2:0] colour,
    output logic       full,
    output logic       plot,
    output logic [9:0] x_out,
    output logic [9:0] y_out,
    output logic [2:0] colour_out,
    input  logic       ready,
    output logic [7:0] clip_count,
    output logic [7:0] drop_count
);

    localparam int AW = $clog2(DEPTH);

    logic [22:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   occ_q, occ_d;
    logic [7:0]    clip_count_q, clip_count_d;
    logic [7:0]    drop_count_q, drop_count_d;
    logic          legal, push, pop;
    logic [22:0]   head;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign full  = (occ_q == (AW+1)'(DEPTH));
    assign plot  = (occ_q != '0);
    assign head  = mem[rd_ptr_q];

    // Outputs are forced to zero while nothing is queued.
    assign x_out      = plot ? head[22:13] : '0;
    assign y_out      = plot ? head[12:3]  : '0;
    assign colour_out = plot ? head[2:0]   : '0;

    always_comb begin
        legal        = (x <= X_MAX) && (y <= Y_MAX);
        pop          = plot && ready;
        push         = writeEn && legal && (!full || pop);
        wr_ptr_d     = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d     = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        occ_d        = occ_q;
        case ({push, pop})
            2'b10:   occ_d = occ_q + (AW+1)'(1);
            2'b01:   occ_d = occ_q - (AW+1)'(1);
            default: occ_d = occ_q;
        endcase
        clip_count_d = (writeEn && !legal) ? sat_inc(clip_count_q) : clip_count_q;
        drop_count_d = (writeEn && legal && full && !pop) ? sat_inc(drop_count_q) : drop_count_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            occ_q        <= '0;
            clip_count_q <= '0;
            drop_count_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            occ_q        <= occ_d;
            clip_count_q <= clip_count_d;
            drop_count_q <= drop_count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push)
            mem[wr_ptr_q] <= {x, y, colour};
    end

    assign clip_count = clip_count_q;
    assign drop_count = drop_count_q;

endmodule
